// File: rtl/pythag_pkg.sv
// Shared definitions for the Pythagorean hypotenuse and leg datapaths.
package pythag_pkg;

    localparam int unsigned PYTHAG_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ROOT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: shift in two radicand bits, try
// subtracting (root<<2)|1, and append the resulting root bit.
module isqrt_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH+1:0] rem_i,
    input  logic [WIDTH-1:0] root_i,
    input  logic [1:0]       bits_i,
    output logic [WIDTH+1:0] rem_o,
    output logic [WIDTH-1:0] root_o
);

    localparam int unsigned RW = WIDTH + 2;

    logic [RW-1:0] rem_sh;
    logic [RW-1:0] trial;
    logic          ge;

    // Trial subtraction; the top remainder bits shifted out are always zero.
    always_comb begin
        rem_sh = RW'({rem_i, bits_i});
        trial  = {root_i, 2'b01};
        ge     = (rem_sh >= trial);
        rem_o  = ge ? (rem_sh - trial) : rem_sh;
        root_o = WIDTH'({root_i, ge});
    end

endmodule

// File: rtl/pythag_leg_solver.sv
// Computes b = floor(sqrt(c*c - a*a)) with a multi-cycle restoring square root,
// flagging perfect squares and the invalid a > c case.
module pythag_leg_solver
    import pythag_pkg::*;
#(
    parameter int unsigned WIDTH = PYTHAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             exact,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned RW = WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [DW-1:0]    d_q, d_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] root_q, root_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             exact_q, exact_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DW-1:0]    sq_c;
    logic [DW-1:0]    sq_a;
    logic [1:0]       dbits;
    logic [RW-1:0]    step_rem;
    logic [WIDTH-1:0] step_root;

    // Full-width squares and the radicand bit pair for the current iteration.
    always_comb begin
        sq_c  = DW'(c_q) * DW'(c_q);
        sq_a  = DW'(a_q) * DW'(a_q);
        dbits = 2'(d_q >> {cnt_q, 1'b0});
    end

    isqrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (dbits),
        .rem_o  (step_rem),
        .root_o (step_root)
    );

    // Next-state and next-output logic for the IDLE/LOAD/ROOT/DONE sequence.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        a_d     = a_q;
        d_d     = d_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        exact_d = exact_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    c_d     = c;
                    a_d     = a;
                    b_d     = '0;
                    exact_d = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (a_q > c_q) begin
                    d_d     = '0;
                    err_d   = 1'b1;
                    b_d     = '0;
                    exact_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    d_d     = sq_c - sq_a;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = ROOT;
                end
            end
            ROOT: begin
                rem_d  = step_rem;
                root_d = step_root;
                if (cnt_q == '0) begin
                    b_d     = step_root;
                    exact_d = (step_rem == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            a_q     <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            a_q     <= a_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            exact_q <= exact_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign b     = b_q;
    assign exact = exact_q;
    assign err   = err_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pythag_leg_solver.sv
// Directed bench for pythag_leg_solver: latency, results, flags, start
// filtering, back-to-back issue and asynchronous reset.
module tb_pythag_leg_solver;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic       exact;
    logic       err;
    logic       busy;
    logic       done;

    int n_chk;
    int n_pass;

    pythag_leg_solver #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .c     (c),
        .a     (a),
        .b     (b),
        .exact (exact),
        .err   (err),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Issue one operation and check latency, busy length, results and hold.
    task automatic run_op(input string tag, input logic [7:0] cc, input logic [7:0] aa,
                          input logic [7:0] eb, input logic ee, input logic er,
                          input int elat);
        int lat;
        int nbusy;
        @(negedge clk);
        c     = cc;
        a     = aa;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 50) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, elat);
        check({tag, ".busy_len"}, nbusy, elat - 1);
        check({tag, ".b"}, b, eb);
        check({tag, ".exact"}, exact, ee);
        check({tag, ".err"}, err, er);
        @(negedge clk);
        check({tag, ".done_one"}, done, 1'b0);
        check({tag, ".b_hold"}, b, eb);
    endtask

    initial begin
        int lat;
        int ndone;
        int t;
        int times [4];

        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        start  = 1'b0;
        c      = '0;
        a      = '0;
        times  = '{0, 0, 0, 0};
        repeat (2) @(negedge clk);
        check("rst.b", b, 8'd0);
        check("rst.exact", exact, 1'b0);
        check("rst.err", err, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        rst = 1'b0;

        run_op("c5a3",     8'd5,   8'd3,   8'd4,   1'b1, 1'b0, 10);
        run_op("c13a5",    8'd13,  8'd5,   8'd12,  1'b1, 1'b0, 10);
        run_op("c10a3",    8'd10,  8'd3,   8'd9,   1'b0, 1'b0, 10);
        run_op("c3a5",     8'd3,   8'd5,   8'd0,   1'b0, 1'b1, 2);
        run_op("c255a0",   8'd255, 8'd0,   8'd255, 1'b1, 1'b0, 10);
        run_op("c0a0",     8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 10);
        run_op("c255a254", 8'd255, 8'd254, 8'd22,  1'b0, 1'b0, 10);

        // Start pulsed mid-ROOT with different operands must be ignored.
        @(negedge clk);
        c     = 8'd13;
        a     = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        repeat (3) begin
            @(negedge clk);
            lat++;
        end
        c     = 8'd255;
        a     = 8'd0;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("ign.lat", lat, 10);
        check("ign.b", b, 8'd12);
        check("ign.exact", exact, 1'b1);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ign.no_extra_done", ndone, 0);

        // Start held high re-triggers once per issue interval.
        @(negedge clk);
        c     = 8'd5;
        a     = 8'd3;
        start = 1'b1;
        t     = 0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (ndone < 4) times[ndone] = t;
                ndone++;
                check("held.b", b, 8'd4);
            end
        end
        start = 1'b0;
        check("held.count", ndone, 3);
        check("held.first", times[0], 10);
        check("held.gap1", times[1] - times[0], 11);
        check("held.gap2", times[2] - times[1], 11);
        repeat (15) @(negedge clk);

        // Asynchronous reset in the middle of ROOT.
        @(negedge clk);
        c     = 8'd13;
        a     = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid.busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid.busy", busy, 1'b0);
        check("mid.done", done, 1'b0);
        check("mid.b", b, 8'd0);
        check("mid.exact", exact, 1'b0);
        check("mid.err", err, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid.no_done", ndone, 0);
        run_op("post_rst", 8'd13, 8'd5, 8'd12, 1'b1, 1'b0, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
